// File: rtl/i2c_write_engine.sv
// Bit-level I2C write master: one START, three bytes each followed by an ACK slot, then STOP.
// Bus timing comes from a quarter-bit tick; every bus output is driven straight from a register.
module i2c_write_engine #(
    parameter int unsigned CLK_DIV = 625
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        GO,
    input  logic [23:0] I2C_DATA,
    output logic        END,
    output logic        ACK,
    output logic        I2C_SCLK,
    inout  wire         I2C_SDAT,
    output logic [1:0]  o_state
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_BITS, S_STOP} state_t;

    localparam logic [15:0] DIV_MAX = 16'(CLK_DIV - 1);

    state_t      r_state;
    logic [1:0]  r_quarter;
    logic [4:0]  r_slot;
    logic [15:0] r_div;
    logic [23:0] r_shift;
    logic        r_go_d;
    logic        r_end;
    logic        r_ack;
    logic        r_sclk;
    logic        r_sda_oe;

    state_t      w_next_state;
    logic [1:0]  w_quarter;
    logic [4:0]  w_slot;
    logic [15:0] w_div;
    logic [23:0] w_shift;
    logic        w_end;
    logic        w_ack;
    logic        w_sclk;
    logic        w_sda_oe;
    logic        w_tick;
    logic        w_start;
    logic        w_sym_done;
    logic        w_ack_slot;
    logic        w_next_ack_slot;
    logic        w_sda_in;

    assign w_sda_in        = I2C_SDAT;
    assign w_tick          = (r_div == DIV_MAX);
    assign w_start         = GO & ~r_go_d;
    assign w_sym_done      = w_tick && (r_quarter == 2'd3);
    assign w_ack_slot      = (r_slot == 5'd8) || (r_slot == 5'd17) || (r_slot == 5'd26);
    assign w_next_ack_slot = (w_slot == 5'd8) || (w_slot == 5'd17) || (w_slot == 5'd26);

    always_ff @(posedge iCLK) begin
        if (iRST_N) begin
            r_state   <= S_IDLE;
            r_quarter <= 2'd0;
            r_slot    <= 5'd0;
            r_div     <= 16'd0;
            r_shift   <= 24'd0;
            r_go_d    <= 1'b0;
            r_end     <= 1'b1;
            r_ack     <= 1'b0;
            r_sclk    <= 1'b1;
            r_sda_oe  <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_quarter <= w_quarter;
            r_slot    <= w_slot;
            r_div     <= w_div;
            r_shift   <= w_shift;
            r_go_d    <= GO;
            r_end     <= w_end;
            r_ack     <= w_ack;
            r_sclk    <= w_sclk;
            r_sda_oe  <= w_sda_oe;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_quarter    = r_quarter;
        w_slot       = r_slot;
        w_div        = w_tick ? 16'd0 : r_div + 16'd1;
        w_shift      = r_shift;
        w_end        = r_end;
        w_ack        = r_ack;
        if (w_tick && (r_state != S_IDLE)) begin
            w_quarter = r_quarter + 2'd1;
        end
        case (r_state)
            S_IDLE: begin
                w_div     = 16'd0;
                w_quarter = 2'd0;
                if (w_start) begin
                    w_next_state = S_START;
                    w_slot       = 5'd0;
                    w_shift      = I2C_DATA;
                    w_end        = 1'b0;
                    w_ack        = 1'b0;
                end
            end
            S_START: begin
                if (w_sym_done) begin
                    w_next_state = S_BITS;
                end
            end
            S_BITS: begin
                // ACK is sampled at the end of q2, while SCL is still high.
                if (w_tick && (r_quarter == 2'd2) && w_ack_slot) begin
                    w_ack = r_ack | w_sda_in;
                end
                if (w_sym_done) begin
                    if (!w_ack_slot) begin
                        w_shift = {r_shift[22:0], 1'b0};
                    end
                    if (r_slot == 5'd26) begin
                        w_next_state = S_STOP;
                        w_slot       = 5'd0;
                    end else begin
                        w_slot = r_slot + 5'd1;
                    end
                end
            end
            S_STOP: begin
                if (w_sym_done) begin
                    w_next_state = S_IDLE;
                    w_end        = 1'b1;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Bus levels are decoded from the next state so the registered outputs line up with it.
    always_comb begin
        w_sclk   = 1'b1;
        w_sda_oe = 1'b0;
        case (w_next_state)
            S_IDLE: begin
                w_sclk   = 1'b1;
                w_sda_oe = 1'b0;
            end
            S_START: begin
                w_sclk   = (w_quarter != 2'd3);
                w_sda_oe = w_quarter[1];
            end
            S_BITS: begin
                w_sclk   = (w_quarter == 2'd1) || (w_quarter == 2'd2);
                w_sda_oe = !w_next_ack_slot && !w_shift[23];
            end
            S_STOP: begin
                w_sclk   = (w_quarter != 2'd0);
                w_sda_oe = !w_quarter[1];
            end
            default: begin
                w_sclk   = 1'b1;
                w_sda_oe = 1'b0;
            end
        endcase
    end

    assign I2C_SDAT = r_sda_oe ? 1'b0 : 1'bz;
    assign I2C_SCLK = r_sclk;
    assign END      = r_end;
    assign ACK      = r_ack;
    assign o_state  = r_state;

endmodule

// File: tb/tb_i2c_write_engine.sv
// Directed bench for i2c_write_engine: bus monitor with slave ACK model, frame timing and payload checks.
module tb_i2c_write_engine;

    localparam int DIV   = 4;
    localparam int FRAME = 116 * DIV;

    logic        iCLK = 1'b0;
    logic        iRST_N;
    logic        GO;
    logic [23:0] I2C_DATA;
    logic        end_o;
    logic        ack_o;
    logic        sclk;
    logic [1:0]  state;
    wire         sda;
    logic        slave_drive = 1'b0;

    pullup (sda);
    assign sda = slave_drive ? 1'b0 : 1'bz;

    i2c_write_engine #(.CLK_DIV(DIV)) dut (
        .iCLK     (iCLK),
        .iRST_N   (iRST_N),
        .GO       (GO),
        .I2C_DATA (I2C_DATA),
        .END      (end_o),
        .ACK      (ack_o),
        .I2C_SCLK (sclk),
        .I2C_SDAT (sda),
        .o_state  (state)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Bus monitor and slave: decodes START/STOP, samples SDA on SCL rises, ACKs unless told to NACK.
    logic        prev_scl = 1'b1;
    logic        prev_sda = 1'b1;
    logic        in_frame = 1'b0;
    int          rises = 0;
    int          start_cnt = 0;
    int          stop_cnt = 0;
    int          last_rises = 0;
    int          nack_byte = -1;
    logic [26:0] cap = '0;
    logic [26:0] last_cap = '0;

    always @(negedge iCLK) begin
        logic cs;
        logic cd;
        cs = sclk;
        cd = sda;
        if (iRST_N === 1'b1) begin
            slave_drive = 1'b0;
            in_frame    = 1'b0;
        end else if (prev_scl && cs && prev_sda && !cd) begin
            start_cnt++;
            in_frame = 1'b1;
            rises    = 0;
        end else if (prev_scl && cs && !prev_sda && cd && in_frame) begin
            stop_cnt++;
            in_frame   = 1'b0;
            last_rises = rises;
            last_cap   = cap;
        end else if (in_frame && !prev_scl && cs) begin
            if (rises < 27) cap[rises[4:0]] = cd;
            rises++;
        end else if (in_frame && prev_scl && !cs) begin
            slave_drive = (rises == 8 && nack_byte != 0) || (rises == 17 && nack_byte != 1) ||
                          (rises == 26 && nack_byte != 2);
        end
        prev_scl = cs;
        prev_sda = cd;
    end

    int e_cyc = 0;
    int end_cyc = 0;
    int s_start = 0;
    int s_stop = 0;

    // Raises GO at the current negedge; returns at the negedge after the recognising edge.
    task automatic frame_begin(input logic [23:0] d, input int nb);
        nack_byte = nb;
        I2C_DATA  = d;
        GO        = 1'b1;
        s_start   = start_cnt;
        s_stop    = stop_cnt;
        @(negedge iCLK);
        e_cyc = cyc;
        check("end_low", end_o, 1'b0);
    endtask

    task automatic frame_finish(input logic [23:0] d, input int nb);
        int len;
        logic [7:0] b0, b1, b2;
        len = -1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge iCLK);
            if (end_o) begin
                len = cyc - e_cyc;
                break;
            end
        end
        end_cyc = cyc;
        check("frame_len", len, FRAME);
        check("ack_flag", ack_o, (nb >= 0));
        check("start_cond", start_cnt - s_start, 1);
        check("stop_cond", stop_cnt - s_stop, 1);
        // 27 BITS rises plus the SCL rise that opens the STOP symbol.
        check("scl_rises", last_rises, 28);
        for (int i = 0; i < 8; i++) begin
            b0[7-i] = last_cap[i];
            b1[7-i] = last_cap[9+i];
            b2[7-i] = last_cap[18+i];
        end
        check("byte0", b0, d[23:16]);
        check("byte1", b1, d[15:8]);
        check("byte2", b2, d[7:0]);
        check("ack_slot0", last_cap[8], (nb == 0));
        check("ack_slot1", last_cap[17], (nb == 1));
        check("ack_slot2", last_cap[26], (nb == 2));
    endtask

    initial begin
        int bad;
        GO       = 1'b0;
        I2C_DATA = 24'd0;
        iRST_N   = 1'b1;
        repeat (3) @(negedge iCLK);
        iRST_N = 1'b0;

        check("rst_sclk", sclk, 1'b1);
        check("rst_sda", sda, 1'b1);
        check("rst_end", end_o, 1'b1);
        check("rst_ack", ack_o, 1'b0);
        check("rst_state", state, 2'd0);
        bad = 0;
        repeat (100) begin
            @(negedge iCLK);
            if (sclk !== 1'b1 || sda !== 1'b1 || end_o !== 1'b1 || ack_o !== 1'b0) bad++;
        end
        check("idle_hold", bad, 0);
        check("idle_no_start", start_cnt, 0);

        // All bytes ACKed.
        frame_begin(24'h34009A, -1);
        GO = 1'b0;
        frame_finish(24'h34009A, -1);

        // Slave NACKs the second byte.
        @(negedge iCLK);
        frame_begin(24'h34009A, 1);
        GO = 1'b0;
        frame_finish(24'h34009A, 1);

        // GO held high for 1000 cycles: only one frame.
        @(negedge iCLK);
        frame_begin(24'h12A5C3, -1);
        frame_finish(24'h12A5C3, -1);
        bad = 0;
        repeat (1000 - FRAME) begin
            @(negedge iCLK);
            if (end_o !== 1'b1) bad++;
        end
        check("go_held_idle", bad, 0);
        check("go_held_frames", start_cnt - s_start, 1);
        GO = 1'b0;
        @(negedge iCLK);
        frame_begin(24'hC35A12, 2);
        GO = 1'b0;
        frame_finish(24'hC35A12, 2);

        // Reset pulse 200 cycles into a frame, then a clean frame.
        @(negedge iCLK);
        frame_begin(24'h34009A, -1);
        GO = 1'b0;
        repeat (199) @(negedge iCLK);
        iRST_N = 1'b1;
        @(negedge iCLK);
        iRST_N = 1'b0;
        check("mid_rst_sclk", sclk, 1'b1);
        check("mid_rst_sda", sda, 1'b1);
        check("mid_rst_end", end_o, 1'b1);
        check("mid_rst_ack", ack_o, 1'b0);
        check("mid_rst_state", state, 2'd0);
        @(negedge iCLK);
        frame_begin(24'h34057F, -1);
        GO = 1'b0;
        frame_finish(24'h34057F, -1);

        // GO edge while busy is ignored; GO edge one cycle after END starts the next frame.
        @(negedge iCLK);
        frame_begin(24'h5A0F3C, -1);
        GO = 1'b0;
        repeat (100) @(negedge iCLK);
        GO = 1'b1;
        repeat (3) @(negedge iCLK);
        GO = 1'b0;
        frame_finish(24'h5A0F3C, -1);
        frame_begin(24'hA5F00F, 0);
        check("b2b_gap", e_cyc - end_cyc, 1);
        GO = 1'b0;
        frame_finish(24'hA5F00F, 0);

        repeat (5) @(negedge iCLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
